alu_step_sequencer: RTL and testbench

Parametrised control-step generator for register-to-register ALU instructions in the multi-cycle datapath. It replaces hand-driven per-state control pulses with a synthesisable Moore FSM that issues the full T0..T5 step sequence. It adds a memory-ready stall, a wide-result mode that writes the 64-bit Z pair into HI/LO, and a register file size set by parameter. It sits between instruction decode and the datapath control inputs.

---
 rtl/alu_step_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_step_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_step_sequencer.sv
// Moore control-step generator for register-to-register ALU instructions (T0..T6).
// Define ALU_SEQ_FETCH_EN to include the T0..T2 fetch steps and the mem_ready stall in T1.
module alu_step_sequencer #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned OPC_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [IDX_W-1:0] ra,
    input  logic [IDX_W-1:0] rb,
    input  logic [IDX_W-1:0] rc,
    input  logic [OPC_W-1:0] op,
    input  logic             wide,
    input  logic             mem_ready,
    output logic             busy,
    output logic             done,
    output logic             bad_idx,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLOout,
    output logic             ZHIout,
    output logic             LOin,
    output logic             HIin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [OPC_W-1:0] ALU_opcode
);

    typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6} state_e;

`ifdef ALU_SEQ_FETCH_EN
    localparam state_e FirstStep = StT0;
`else
    localparam state_e FirstStep = StT3;
`endif

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ra_q, rb_q, rc_q, ra_d, rb_d, rc_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic             wide_q, wide_d;
    logic             final_step, accept, bad_d;

    // Out-of-range indices match no bit, giving an all-zero enable.
    function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREGS-1:0] oh;
        for (int unsigned i = 0; i < NREGS; i++) oh[i] = (32'(idx) == i);
        return oh;
    endfunction

    always_comb begin
        final_step = (state_q == StT6) || (state_q == StT5 && !wide_q);
        accept     = start && (state_q == StIdle || final_step);
        bad_d      = (32'(ra) >= NREGS) || (32'(rb) >= NREGS) || (32'(rc) >= NREGS);
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        op_d       = op_q;
        wide_d     = wide_q;
        if (accept) begin
            ra_d   = ra;
            rb_d   = rb;
            rc_d   = rc;
            op_d   = op;
            wide_d = wide;
        end
        state_d = StIdle;
        case (state_q)
`ifdef ALU_SEQ_FETCH_EN
            StT0:    state_d = StT1;
            StT1:    state_d = mem_ready ? StT2 : StT1;
            StT2:    state_d = StT3;
`endif
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = wide_q ? StT6 : StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) state_d = FirstStep;
    end

`ifndef ALU_SEQ_FETCH_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign PCout  = 1'b0;
    assign MARin  = 1'b0;
    assign IncPC  = 1'b0;
    assign PCin   = 1'b0;
    assign Read   = 1'b0;
    assign MDRin  = 1'b0;
    assign MDRout = 1'b0;
    assign IRin   = 1'b0;
`endif

    // Outputs are registered from the next state, so they line up with state_q.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            op_q       <= '0;
            wide_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bad_idx    <= 1'b0;
`ifdef ALU_SEQ_FETCH_EN
            PCout      <= 1'b0;
            MARin      <= 1'b0;
            IncPC      <= 1'b0;
            PCin       <= 1'b0;
            Read       <= 1'b0;
            MDRin      <= 1'b0;
            MDRout     <= 1'b0;
            IRin       <= 1'b0;
`endif
            Zin        <= 1'b0;
            Yin        <= 1'b0;
            ZLOout     <= 1'b0;
            ZHIout     <= 1'b0;
            LOin       <= 1'b0;
            HIin       <= 1'b0;
            Rin        <= '0;
            Rout       <= '0;
            ALU_opcode <= '0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rc_q       <= rc_d;
            op_q       <= op_d;
            wide_q     <= wide_d;
            busy       <= (state_d != StIdle);
            done       <= (state_d == StT6) || (state_d == StT5 && !wide_d);
            if (accept) bad_idx <= bad_d;
`ifdef ALU_SEQ_FETCH_EN
            PCout      <= 1'b0;
            MARin      <= 1'b0;
            IncPC      <= 1'b0;
            PCin       <= 1'b0;
            Read       <= 1'b0;
            MDRin      <= 1'b0;
            MDRout     <= 1'b0;
            IRin       <= 1'b0;
`endif
            Zin        <= 1'b0;
            Yin        <= 1'b0;
            ZLOout     <= 1'b0;
            ZHIout     <= 1'b0;
            LOin       <= 1'b0;
            HIin       <= 1'b0;
            Rin        <= '0;
            Rout       <= '0;
            ALU_opcode <= '0;
            case (state_d)
`ifdef ALU_SEQ_FETCH_EN
                StT0: begin
                    PCout <= 1'b1;
                    MARin <= 1'b1;
                    IncPC <= 1'b1;
                    Zin   <= 1'b1;
                end
                StT1: begin
                    ZLOout <= 1'b1;
                    PCin   <= (state_q != StT1);
                    Read   <= 1'b1;
                    MDRin  <= 1'b1;
                end
                StT2: begin
                    MDRout <= 1'b1;
                    IRin   <= 1'b1;
                end
`endif
                StT3: begin
                    Rout <= onehot(rb_d);
                    Yin  <= 1'b1;
                end
                StT4: begin
                    Rout       <= onehot(rc_d);
                    Zin        <= 1'b1;
                    ALU_opcode <= op_d;
                end
                StT5: begin
                    ZLOout <= 1'b1;
                    if (wide_d) LOin <= 1'b1;
                    else        Rin  <= onehot(ra_d);
                end
                StT6: begin
                    ZHIout <= 1'b1;
                    HIin   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer; runs a 16-register and an 8-register instance in lockstep.
module tb_alu_step_sequencer;

    typedef enum int {SIdle, S0, S1, S2, S3, S4, S5, S6} step_e;

    typedef struct {
        string       tag;
        logic [53:0] v16;
        logic [53:0] v8;
    } exp_t;

    logic clk = 1'b0;
    logic clr, start, wide, mem_ready;
    logic [3:0] ra, rb, rc;
    logic [4:0] op;

    logic busy, done, bad_idx, pcout, marin, incpc, zin, pcin, read, mdrin, mdrout, irin;
    logic yin, zloout, zhiout, loin, hiin;
    logic [15:0] rin, rout;
    logic [4:0] opc;

    logic busy8, done8, bad8_o, pcout8, marin8, incpc8, zin8, pcin8, read8, mdrin8, mdrout8;
    logic irin8, yin8, zloout8, zhiout8, loin8, hiin8;
    logic [7:0] rin8, rout8;
    logic [4:0] opc8;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [3:0] cur_a, cur_b, cur_c;
    logic [4:0] cur_o;
    logic cur_w, bad16, bad8;

    always #5 clk = ~clk;

    alu_step_sequencer #(.NREGS(16), .IDX_W(4), .OPC_W(5)) dut (
        .clk(clk), .clr(clr), .start(start), .ra(ra), .rb(rb), .rc(rc), .op(op), .wide(wide),
        .mem_ready(mem_ready), .busy(busy), .done(done), .bad_idx(bad_idx), .PCout(pcout),
        .MARin(marin), .IncPC(incpc), .Zin(zin), .PCin(pcin), .Read(read), .MDRin(mdrin),
        .MDRout(mdrout), .IRin(irin), .Yin(yin), .ZLOout(zloout), .ZHIout(zhiout), .LOin(loin),
        .HIin(hiin), .Rin(rin), .Rout(rout), .ALU_opcode(opc)
    );

    alu_step_sequencer #(.NREGS(8), .IDX_W(4), .OPC_W(5)) dut8 (
        .clk(clk), .clr(clr), .start(start), .ra(ra), .rb(rb), .rc(rc), .op(op), .wide(wide),
        .mem_ready(mem_ready), .busy(busy8), .done(done8), .bad_idx(bad8_o), .PCout(pcout8),
        .MARin(marin8), .IncPC(incpc8), .Zin(zin8), .PCin(pcin8), .Read(read8), .MDRin(mdrin8),
        .MDRout(mdrout8), .IRin(irin8), .Yin(yin8), .ZLOout(zloout8), .ZHIout(zhiout8),
        .LOin(loin8), .HIin(hiin8), .Rin(rin8), .Rout(rout8), .ALU_opcode(opc8)
    );

    function automatic logic [15:0] oh(input logic [3:0] idx, input int unsigned n);
        logic [15:0] one;
        one = 16'h0001;
        if (32'(idx) < n) return one << idx;
        return '0;
    endfunction

    // Packing: {busy, done, bad_idx, 14 strobes PCout..HIin, Rin, Rout, ALU_opcode}
    function automatic logic [53:0] model(input step_e s, input logic [3:0] a, b, c,
                                          input logic [4:0] o, input logic w, pc1, bad,
                                          input int unsigned n);
        logic [13:0] stb;
        logic [15:0] rin_e, rout_e;
        logic [4:0]  opc_e;
        stb = '0;
        rin_e = '0;
        rout_e = '0;
        opc_e = '0;
        case (s)
            S0: stb = 14'b11110000000000;
            S1: stb = {4'b0000, pc1, 9'b110001000};
            S2: stb = 14'b00000001100000;
            S3: begin stb = 14'b00000000010000; rout_e = oh(b, n); end
            S4: begin stb = 14'b00010000000000; rout_e = oh(c, n); opc_e = o; end
            S5: begin
                stb = w ? 14'b00000000001010 : 14'b00000000001000;
                if (!w) rin_e = oh(a, n);
            end
            S6: stb = 14'b00000000000101;
            default: ;
        endcase
        return {(s != SIdle), ((s == S5 && !w) || s == S6), bad, stb, rin_e, rout_e, opc_e};
    endfunction

    task automatic cycle(input string tag, input step_e s, input logic pc1);
        exp_t e;
        logic [53:0] got16, got8;
        e.tag = tag;
        e.v16 = model(s, cur_a, cur_b, cur_c, cur_o, cur_w, pc1, bad16, 16);
        e.v8  = model(s, cur_a, cur_b, cur_c, cur_o, cur_w, pc1, bad8, 8);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got16 = {busy, done, bad_idx, pcout, marin, incpc, zin, pcin, read, mdrin, mdrout, irin,
                 yin, zloout, zhiout, loin, hiin, rin, rout, opc};
        got8  = {busy8, done8, bad8_o, pcout8, marin8, incpc8, zin8, pcin8, read8, mdrin8,
                 mdrout8, irin8, yin8, zloout8, zhiout8, loin8, hiin8, 8'h00, rin8, 8'h00, rout8,
                 opc8};
        checks++;
        assert (got16 === e.v16) else begin
            failures++;
            $error("FAIL %s nregs16 observed=%h expected=%h", e.tag, got16, e.v16);
        end
        checks++;
        assert (got8 === e.v8) else begin
            failures++;
            $error("FAIL %s nregs8 observed=%h expected=%h", e.tag, got8, e.v8);
        end
    endtask

    task automatic issue(input logic [3:0] a, b, c, input logic [4:0] o, input logic w);
        ra = a; rb = b; rc = c; op = o; wide = w; start = 1'b1;
        cur_a = a; cur_b = b; cur_c = c; cur_o = o; cur_w = w;
        bad16 = (32'(a) >= 16) || (32'(b) >= 16) || (32'(c) >= 16);
        bad8  = (32'(a) >= 8) || (32'(b) >= 8) || (32'(c) >= 8);
    endtask

    // Covers the cycles from the first step to the final (done) step.
    task automatic run_seq(input string tag, input int stalls, input logic hold);
`ifdef ALU_SEQ_FETCH_EN
        cycle({tag, "_t0"}, S0, 1'b0);
        if (!hold) start = 1'b0;
        cycle({tag, "_t1"}, S1, 1'b1);
        mem_ready = (stalls == 0);
        for (int i = 0; i < stalls; i++) begin
            cycle({tag, "_t1stall"}, S1, 1'b0);
            mem_ready = (i == stalls - 1);
        end
        cycle({tag, "_t2"}, S2, 1'b0);
        cycle({tag, "_t3"}, S3, 1'b0);
`else
        cycle({tag, "_t3"}, S3, 1'b0);
`endif
        if (!hold) start = 1'b0;
        cycle({tag, "_t4"}, S4, 1'b0);
        cycle({tag, "_t5"}, S5, 1'b0);
        if (cur_w) cycle({tag, "_t6"}, S6, 1'b0);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; ra = '0; rb = '0; rc = '0; op = '0; wide = 1'b0;
        mem_ready = 1'b1;
        cur_a = '0; cur_b = '0; cur_c = '0; cur_o = '0; cur_w = 1'b0;
        bad16 = 1'b0; bad8 = 1'b0;
        #2;
        cycle("reset", SIdle, 1'b0);
        cycle("reset", SIdle, 1'b0);
        clr = 1'b0;
        cycle("idle", SIdle, 1'b0);

        issue(4'd0, 4'd4, 4'd5, 5'b00100, 1'b0);
        run_seq("normal", 0, 1'b0);
        cycle("normal_end", SIdle, 1'b0);

        issue(4'd2, 4'd6, 4'd1, 5'b01010, 1'b0);
        run_seq("stall", 3, 1'b0);
        cycle("stall_end", SIdle, 1'b0);

        issue(4'd0, 4'd2, 4'd3, 5'b00011, 1'b1);
        run_seq("wide", 0, 1'b0);
        cycle("wide_end", SIdle, 1'b0);

        // start held high; only the final-step cycle may accept the second instruction
        issue(4'd1, 4'd4, 4'd5, 5'b00100, 1'b0);
        run_seq("b2b_a", 0, 1'b1);
        issue(4'd7, 4'd4, 4'd5, 5'b00100, 1'b0);
        run_seq("b2b_b", 0, 1'b0);
        cycle("b2b_end", SIdle, 1'b0);

        // clr during T4 with a mid-sequence start that must be ignored
        issue(4'd6, 4'd2, 4'd3, 5'b00111, 1'b0);
`ifdef ALU_SEQ_FETCH_EN
        cycle("rst_t0", S0, 1'b0);
        cycle("rst_t1", S1, 1'b1);
        cycle("rst_t2", S2, 1'b0);
`endif
        cycle("rst_t3", S3, 1'b0);
        ra = 4'd9; rb = 4'd1; rc = 4'd1; op = 5'b11111;
        cycle("rst_t4_ignore_start", S4, 1'b0);
        clr = 1'b1;
        bad16 = 1'b0; bad8 = 1'b0;
        cycle("rst_clr", SIdle, 1'b0);
        clr = 1'b0; start = 1'b0;
        cycle("rst_idle", SIdle, 1'b0);
        issue(4'd6, 4'd2, 4'd3, 5'b00111, 1'b0);
        run_seq("rst_again", 0, 1'b0);
        cycle("rst_again_end", SIdle, 1'b0);

        clr = 1'b1; start = 1'b1; ra = 4'd3;
        cycle("clr_start", SIdle, 1'b0);
        clr = 1'b0; start = 1'b0;
        cycle("clr_start_idle", SIdle, 1'b0);

        issue(4'd0, 4'd1, 4'd9, 5'b00001, 1'b0);
        run_seq("bad", 0, 1'b0);
        cycle("bad_sticky", SIdle, 1'b0);
        cycle("bad_sticky", SIdle, 1'b0);
        issue(4'd3, 4'd2, 4'd1, 5'b00010, 1'b0);
        run_seq("bad_clear", 0, 1'b0);
        cycle("bad_clear_end", SIdle, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
